// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Purpose:
//   Boot-time front end of the single-cycle CPU. It takes a byte stream over a
//   valid/ready port and assembles little-endian 32-bit instruction words. Each
//   word is written into instruction memory. The stream is checked against a
//   trailing XOR checksum. A good checksum raises start, which is sticky and
//   releases the CPU. A bad checksum or an oversize word count raises error,
//   which is also sticky, and start stays low.
//
// Frame on the wire:
//   CNT_LO, CNT_HI   16-bit word count N (little-endian)
//   4*N data bytes   each word little-endian (first byte = bits[7:0])
//   CHK              XOR of all data bytes (0x00 when N = 0)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_valid      in_data holds a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle (registered)
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     word address, valid while imem_we = 1
//   imem_wdata    instruction word, valid while imem_we = 1
//   start         CPU run enable, sticky until rst
//   busy          load in progress
//   error         load failed, sticky until rst
//   words_loaded  number of words written so far
// -----------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              start,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);
   localparam logic [31:0]       MAX_WORDS_U = 32'(MAX_WORDS);

   state_t            state_q, state_d;
   logic [7:0]        cnt_lo_q, cnt_lo_d;
   logic [15:0]       words_left_q, words_left_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       word_buf_q, word_buf_d;
   logic [7:0]        xor_q, xor_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              in_ready_q, in_ready_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

   logic              accept;
   logic [15:0]       count_full;

   // in_ready is a flop, so a byte can only be taken while the FSM is known
   // to be in a receiving state. Once a terminal state is reached, no further
   // byte is consumed.
   assign accept     = in_valid && in_ready_q;
   assign count_full = {in_data, cnt_lo_q};

   always_comb begin
      state_d        = state_q;
      cnt_lo_d       = cnt_lo_q;
      words_left_d   = words_left_q;
      byte_idx_d     = byte_idx_q;
      word_buf_d     = word_buf_q;
      xor_d          = xor_q;
      waddr_d        = waddr_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      words_loaded_d = words_loaded_q;
      start_d        = start_q;
      error_d        = error_q;

      case (state_q)
         S_CNT_LO: begin
            if (accept) begin
               cnt_lo_d = in_data;
               state_d  = S_CNT_HI;
            end
         end

         S_CNT_HI: begin
            if (accept) begin
               xor_d      = 8'h00;
               byte_idx_d = 2'd0;
               waddr_d    = BASE_A;
               if ({16'd0, count_full} > MAX_WORDS_U) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else if (count_full == 16'd0) begin
                  state_d = S_CHK;
               end else begin
                  words_left_d = count_full;
                  state_d      = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               xor_d      = xor_q ^ in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_buf_d[7:0]   = in_data;
                  2'd1: word_buf_d[15:8]  = in_data;
                  2'd2: word_buf_d[23:16] = in_data;
                  default: begin
                     // The 4th byte completes the word. It goes straight into
                     // the write register, so the strobe appears on the next
                     // edge without staging.
                     imem_we_d      = 1'b1;
                     imem_addr_d    = waddr_q;
                     imem_wdata_d   = {in_data, word_buf_q};
                     waddr_d        = waddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                     words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
                     words_left_d   = words_left_q - 16'd1;
                     if (words_left_q == 16'd1) begin
                        state_d = S_CHK;
                     end
                  end
               endcase
            end
         end

         S_CHK: begin
            if (accept) begin
               if (in_data == xor_q) begin
                  state_d = S_DONE;
                  start_d = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end

         default: begin
            // S_DONE / S_ERR hold until reset.
         end
      endcase

      // Handshake and status follow the next state. This makes in_ready and
      // busy drop on the same edge that enters a terminal state.
      in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
      busy_d     = (state_d == S_CNT_HI) || (state_d == S_DATA) || (state_d == S_CHK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_CNT_LO;
         cnt_lo_q       <= 8'h00;
         words_left_q   <= 16'd0;
         byte_idx_q     <= 2'd0;
         word_buf_q     <= 24'd0;
         xor_q          <= 8'h00;
         waddr_q        <= '0;
         in_ready_q     <= 1'b0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= 32'd0;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_lo_q       <= cnt_lo_d;
         words_left_q   <= words_left_d;
         byte_idx_q     <= byte_idx_d;
         word_buf_q     <= word_buf_d;
         xor_q          <= xor_d;
         waddr_q        <= waddr_d;
         in_ready_q     <= in_ready_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         start_q        <= start_d;
         busy_q         <= busy_d;
         error_q        <= error_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign start        = start_q;
   assign busy         = busy_q;
   assign error        = error_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Drives byte frames into imem_boot_loader. Each frame is scored against a
// frame-level model: it parses the count, the words and the checksum, and
// predicts which bytes are taken, the ordered list of memory writes, and the
// final start/error/busy/in_ready/words_loaded state. Directed frames come
// first, then randomized frames.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;
   localparam int MAXW   = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              start;
   logic              busy;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int checks = 0;
   int errors = 0;
   int acc_count = 0;

   logic [ADDR_W-1:0] got_addr[$];
   logic [31:0]       got_data[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   logic [7:0]        frame[$];

   imem_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .start        (start),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Observe the bus: count handshakes and record every cycle imem_we is high.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) acc_count++;
      if (!rst && imem_we) begin
         got_addr.push_back(imem_addr);
         got_data.push_back(imem_wdata);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      frame.push_back(w[7:0]);
      frame.push_back(w[15:8]);
      frame.push_back(w[23:16]);
      frame.push_back(w[31:24]);
   endtask

   // Frame-level reference: what should be accepted, written and concluded.
   task automatic model(output int acc_len, output int fin);
      int n, words, need;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      acc_len = frame.size();
      fin = 0;
      if (frame.size() < 2) return;
      n = int'(frame[0]) + 256 * int'(frame[1]);
      if (n > MAXW) begin
         acc_len = 2;
         fin = 2;
         return;
      end
      need = 2 + 4 * n + 1;
      words = (frame.size() - 2) / 4;
      if (words > n) words = n;
      for (int w = 0; w < words; w++) begin
         exp_addr.push_back(ADDR_W'(w));
         exp_data.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
      end
      if (frame.size() >= need) begin
         x = 8'h00;
         for (int k = 2; k < need - 1; k++) x ^= frame[k];
         fin = (frame[need-1] == x) ? 1 : 2;
         acc_len = need;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input int bound, output bit ok);
      int n;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (in_ready === 1'b1) begin
         @(negedge clk);
         ok = 1'b1;
      end else begin
         ok = 1'b0;
         in_valid = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_words_loaded"}, words_loaded, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_all_zero("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready_low_before_edge", in_ready, 0);
      @(negedge clk);
      check("rst_ready_rises", in_ready, 1);
      check("rst_busy_idle", busy, 0);
   endtask

   task automatic run_frame(input string tag, input int max_gap);
      int acc_len, fin, base_acc, base_wr, gap, nw;
      bit ok, exp_ok, term;
      model(acc_len, fin);
      base_acc = acc_count;
      base_wr  = got_addr.size();
      for (int i = 0; i < frame.size(); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         exp_ok = (i < acc_len);
         send_byte(frame[i], gap, exp_ok ? 40 : 6, ok);
         check({tag, "_accept"}, ok, exp_ok);
         if (ok && exp_ok) begin
            term = (fin != 0) && (i == acc_len - 1);
            check({tag, "_busy_step"}, busy, !term);
            check({tag, "_ready_step"}, in_ready, !term);
         end
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      nw = got_addr.size() - base_wr;
      check({tag, "_accepted"}, acc_count - base_acc, acc_len);
      check({tag, "_n_writes"}, nw, exp_addr.size());
      for (int w = 0; w < exp_addr.size() && w < nw; w++) begin
         check({tag, "_waddr"}, got_addr[base_wr+w], exp_addr[w]);
         check({tag, "_wdata"}, got_data[base_wr+w], exp_data[w]);
      end
      check({tag, "_start"}, start, fin == 1);
      check({tag, "_error"}, error, fin == 2);
      check({tag, "_busy"}, busy, fin == 0 && acc_len > 0);
      check({tag, "_in_ready"}, in_ready, fin == 0);
      check({tag, "_words_loaded"}, words_loaded, exp_addr.size());
      check({tag, "_excl"}, start & error, 0);
      $display("frame %s bytes=%0d accepted=%0d writes=%0d start=%0b error=%0b",
               tag, frame.size(), acc_count - base_acc, nw, start, error);
   endtask

   task automatic build_test1(input logic [7:0] chk);
      frame.delete();
      frame.push_back(8'h02);
      frame.push_back(8'h00);
      push_word(32'h00500293);
      push_word(32'h00600313);
      frame.push_back(chk);
   endtask

   initial begin
      int n, wr0;
      logic [7:0] x;
      logic [31:0] w;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_reset();

      // Normal load, checked against the literal expected instruction words.
      build_test1(8'hB1);
      wr0 = got_data.size();
      run_frame("normal", 0);
      check("normal_mem0", (got_data.size() > wr0) ? got_data[wr0] : 32'hx, 32'h00500293);
      check("normal_mem1", (got_data.size() > wr0 + 1) ? got_data[wr0+1] : 32'hx, 32'h00600313);

      // Bad checksum: both writes happen, then error.
      do_reset();
      build_test1(8'hB0);
      run_frame("badchk", 0);

      // Empty frame.
      do_reset();
      frame.delete();
      frame.push_back(8'h00);
      frame.push_back(8'h00);
      frame.push_back(8'h00);
      run_frame("empty", 0);

      // Oversize count, followed by bytes that must be ignored.
      do_reset();
      frame.delete();
      frame.push_back(8'h01);
      frame.push_back(8'h01);
      frame.push_back(8'h93);
      frame.push_back(8'h02);
      run_frame("oversize", 0);

      // Exactly MAX_WORDS is allowed: the header alone must leave the loader busy.
      do_reset();
      frame.delete();
      frame.push_back(8'h00);
      frame.push_back(8'h01);
      run_frame("maxcount_hdr", 0);

      // Backpressure: random idle cycles between bytes.
      do_reset();
      build_test1(8'hB1);
      run_frame("backpressure", 3);

      // Reset in the middle of a word, then a clean reload.
      do_reset();
      frame.delete();
      frame.push_back(8'h02);
      frame.push_back(8'h00);
      frame.push_back(8'h93);
      frame.push_back(8'h02);
      run_frame("partial", 0);
      do_reset();
      build_test1(8'hB1);
      run_frame("reload", 1);

      // Randomized frames: random length and content, sometimes a corrupted
      // checksum, sometimes trailing junk, sometimes an oversize count.
      for (int t = 0; t < 8; t++) begin
         do_reset();
         frame.delete();
         if (t == 7) begin
            n = int'($urandom_range(MAXW + 1, 65535));
            frame.push_back(8'(n));
            frame.push_back(8'(n >> 8));
            frame.push_back(8'($urandom));
         end else begin
            n = int'($urandom_range(0, 5));
            frame.push_back(8'(n));
            frame.push_back(8'h00);
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
               w = $urandom;
               push_word(w);
               x ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
            if ($urandom_range(0, 2) == 0) x ^= 8'(int'($urandom_range(1, 255)));
            frame.push_back(x);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) frame.push_back(8'($urandom));
         end
         run_frame("random", 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
